debounce_multi: RTL and testbench

Parametrised multi-channel debouncer for the board's push-buttons and slide switches. It replaces per-input single-channel debouncers with one block that has:
- a 2-flop synchroniser and stability counter per channel,
- registered rise/fall event pulses,
- optional per-channel bounce statistics.

It sits between the raw FPGA pins and the drawing/cursor control logic, which consumes the clean levels and one-cycle edge pulses.

---
 rtl/debounce_pkg.sv | 11 +
 rtl/debounce_chan.sv | 94 +++++++++
 rtl/debounce_multi.sv | 76 +++++++
 tb/tb_debounce_multi.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel debouncer.
package debounce_pkg;

  localparam int BOUNCE_CNT_W = 16;
  localparam logic [BOUNCE_CNT_W-1:0] BOUNCE_CNT_MAX = 16'hFFFF;

  function automatic int stabCntWidth(input int stableCycles);
    return (stableCycles > 2) ? $clog2(stableCycles) : 1;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debouncer channel: 2-flop synchroniser, saturating stability counter, clean level,
// registered edge pulses and, with DEBOUNCE_BOUNCE_CNT_EN defined, a saturating bounce counter.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = 32768,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bouncy_i,
  input  logic                    cnt_clr_i,
  output logic                    clean_o,
  output logic                    rise_o,
  output logic                    fall_o,
  output logic [BOUNCE_CNT_W-1:0] bounce_cnt_o
);

  localparam int CNT_W = stabCntWidth(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             meta_q, sync_q, prev_q, clean_q, rise_q, fall_q;
  logic [CNT_W-1:0] stabCnt_q, stabCnt_d;
  logic             changed, update;

  assign changed = (sync_q != prev_q);

  always_comb begin
    stabCnt_d = stabCnt_q;
    if (changed) begin
      stabCnt_d = '0;
    end else if (stabCnt_q != CNT_MAX) begin
      stabCnt_d = stabCnt_q + 1'b1;
    end
  end

  // A saturated counter alone is not enough: the edge where sync first differs from
  // prev still sees the old saturated count, so the update also requires sync == prev.
  assign update = !changed && (stabCnt_q == CNT_MAX) && (sync_q != clean_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q    <= RESET_LEVEL;
      sync_q    <= RESET_LEVEL;
      prev_q    <= RESET_LEVEL;
      clean_q   <= RESET_LEVEL;
      stabCnt_q <= '0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      meta_q    <= bouncy_i;
      sync_q    <= meta_q;
      prev_q    <= sync_q;
      stabCnt_q <= stabCnt_d;
      if (update) begin
        clean_q <= sync_q;
      end
      rise_q <= update && sync_q;
      fall_q <= update && !sync_q;
    end
  end

  assign clean_o = clean_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

`ifdef DEBOUNCE_BOUNCE_CNT_EN
  logic [BOUNCE_CNT_W-1:0] bounceCnt_q, bounceCnt_d;

  always_comb begin
    bounceCnt_d = bounceCnt_q;
    if (cnt_clr_i) begin
      bounceCnt_d = '0;
    end else if (changed && (bounceCnt_q != BOUNCE_CNT_MAX)) begin
      bounceCnt_d = bounceCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bounceCnt_q <= '0;
    end else begin
      bounceCnt_q <= bounceCnt_d;
    end
  end

  assign bounce_cnt_o = bounceCnt_q;
`else
  logic unusedClr;
  assign unusedClr    = cnt_clr_i;
  assign bounce_cnt_o = '0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer top: one debounce_chan per input, bounce-count read mux and clear decode.
// Bounce statistics are built only when DEBOUNCE_BOUNCE_CNT_EN is defined; otherwise bounce_cnt is 0.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int   NUM_CH        = 4,
  parameter int   STABLE_CYCLES = 32768,
  parameter logic RESET_LEVEL   = 1'b0,
  localparam int  SEL_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       bouncy_in,
  output logic [NUM_CH-1:0]       clean_out,
  output logic [NUM_CH-1:0]       rise_pulse,
  output logic [NUM_CH-1:0]       fall_pulse,
  output logic                    any_change,
  input  logic [SEL_W-1:0]        cnt_sel,
  input  logic                    cnt_clr,
  output logic [BOUNCE_CNT_W-1:0] bounce_cnt
);

  logic [NUM_CH-1:0]                   clrVec;
  logic [NUM_CH-1:0][BOUNCE_CNT_W-1:0] chanCnt;

  for (genvar i = 0; i < NUM_CH; i++) begin : gChan
    assign clrVec[i] = cnt_clr && (cnt_sel == SEL_W'(i));

    debounce_chan #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .RESET_LEVEL  (RESET_LEVEL)
    ) uChan (
      .clk         (clk),
      .rst         (rst),
      .bouncy_i    (bouncy_in[i]),
      .cnt_clr_i   (clrVec[i]),
      .clean_o     (clean_out[i]),
      .rise_o      (rise_pulse[i]),
      .fall_o      (fall_pulse[i]),
      .bounce_cnt_o(chanCnt[i])
    );
  end

  assign any_change = |{rise_pulse, fall_pulse};

`ifdef DEBOUNCE_BOUNCE_CNT_EN
  localparam int SEL_N = 2 ** SEL_W;

  // Padding the read array to the full select range makes out-of-range selects read 0.
  logic [SEL_N-1:0][BOUNCE_CNT_W-1:0] cntPad;
  logic [BOUNCE_CNT_W-1:0]            readCnt_q;

  for (genvar j = 0; j < SEL_N; j++) begin : gPad
    if (j < NUM_CH) begin : gUsed
      assign cntPad[j] = chanCnt[j];
    end else begin : gZero
      assign cntPad[j] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readCnt_q <= '0;
    end else begin
      readCnt_q <= cntPad[cnt_sel];
    end
  end

  assign bounce_cnt = readCnt_q;
`else
  logic unusedCnt;
  assign unusedCnt  = ^chanCnt;
  assign bounce_cnt = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: directed scenarios plus random bouncing, checked
// every cycle against a sample-history model, on a RESET_LEVEL=0 and a RESET_LEVEL=1 instance.
module tb_debounce_multi;

  localparam int NUM_CH = 4;
  localparam int S      = 4;
  localparam int H      = S + 3;
`ifdef DEBOUNCE_BOUNCE_CNT_EN
  localparam bit BOUNCE_EN = 1'b1;
`else
  localparam bit BOUNCE_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] bouncy_in;
  logic [1:0]        cnt_sel;
  logic              cnt_clr;
  logic [NUM_CH-1:0] cleanLo, riseLo, fallLo, cleanHi, riseHi, fallHi;
  logic              anyLo, anyHi;
  logic [15:0]       cntLo, cntHi;

  int checks   = 0;
  int failures = 0;

  always #10 clk = ~clk;

  debounce_multi #(.NUM_CH(NUM_CH), .STABLE_CYCLES(S), .RESET_LEVEL(1'b0)) dutLo (
    .clk(clk), .rst(rst), .bouncy_in(bouncy_in), .clean_out(cleanLo), .rise_pulse(riseLo),
    .fall_pulse(fallLo), .any_change(anyLo), .cnt_sel(cnt_sel), .cnt_clr(cnt_clr),
    .bounce_cnt(cntLo));

  debounce_multi #(.NUM_CH(NUM_CH), .STABLE_CYCLES(S), .RESET_LEVEL(1'b1)) dutHi (
    .clk(clk), .rst(rst), .bouncy_in(bouncy_in), .clean_out(cleanHi), .rise_pulse(riseHi),
    .fall_pulse(fallHi), .any_change(anyHi), .cnt_sel(cnt_sel), .cnt_clr(cnt_clr),
    .bounce_cnt(cntHi));

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", tag, actual, expected, $time);
    end
  endtask

  // Model: per channel the last S+3 raw samples. The output may move to v only once the
  // S+1 samples that have passed the synchroniser are all v; bounces are changes in that stream.
  bit hist   [2][NUM_CH][H];
  bit mClean [2][NUM_CH];
  bit mRise  [2][NUM_CH];
  bit mFall  [2][NUM_CH];
  int mBounce[2][NUM_CH];
  int mRead  [2];

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mRead[k] = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int h = 0; h < H; h++) hist[k][c][h] = (k == 1);
        mClean[k][c]  = (k == 1);
        mRise[k][c]   = 1'b0;
        mFall[k][c]   = 1'b0;
        mBounce[k][c] = 0;
      end
    end
  endtask

  task automatic modelStep();
    bit allSame;
    for (int k = 0; k < 2; k++) begin
      mRead[k] = mBounce[k][int'(cnt_sel)];
      for (int c = 0; c < NUM_CH; c++) begin
        for (int h = 0; h < H - 1; h++) hist[k][c][h] = hist[k][c][h+1];
        hist[k][c][H-1] = bouncy_in[c];
        if (cnt_clr && (int'(cnt_sel) == c)) mBounce[k][c] = 0;
        else if ((hist[k][c][H-3] != hist[k][c][H-4]) && (mBounce[k][c] < 65535)) mBounce[k][c]++;
        allSame = 1'b1;
        for (int h = 1; h <= S; h++) if (hist[k][c][h] != hist[k][c][0]) allSame = 1'b0;
        mRise[k][c] = 1'b0;
        mFall[k][c] = 1'b0;
        if (allSame && (hist[k][c][0] != mClean[k][c])) begin
          mClean[k][c] = hist[k][c][0];
          mRise[k][c]  = hist[k][c][0];
          mFall[k][c]  = !hist[k][c][0];
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) modelReset();
    else     modelStep();
  end

  int riseCnt[2][NUM_CH];
  int fallCnt[2][NUM_CH];

  task automatic compareInst(input int k);
    logic [NUM_CH-1:0] eC, eR, eF;
    for (int c = 0; c < NUM_CH; c++) begin
      eC[c] = mClean[k][c];
      eR[c] = mRise[k][c];
      eF[c] = mFall[k][c];
    end
    checkOutput(k ? "clean_hi" : "clean_lo", k ? cleanHi : cleanLo, eC);
    checkOutput(k ? "rise_hi"  : "rise_lo",  k ? riseHi  : riseLo,  eR);
    checkOutput(k ? "fall_hi"  : "fall_lo",  k ? fallHi  : fallLo,  eF);
    checkOutput(k ? "any_hi"   : "any_lo",   k ? anyHi   : anyLo,   |{eR, eF});
    checkOutput(k ? "bcnt_hi"  : "bcnt_lo",  k ? cntHi   : cntLo,   BOUNCE_EN ? mRead[k] : 0);
  endtask

  always @(negedge clk) begin
    compareInst(0);
    compareInst(1);
    for (int c = 0; c < NUM_CH; c++) begin
      riseCnt[0][c] += riseLo[c];
      fallCnt[0][c] += fallLo[c];
      riseCnt[1][c] += riseHi[c];
      fallCnt[1][c] += fallHi[c];
    end
  end

  // Called at a falling edge; drives the raw inputs and waits the given number of cycles.
  task automatic applyStimulus(input logic [NUM_CH-1:0] bits, input int cycles);
    bouncy_in = bits;
    repeat (cycles) @(negedge clk);
  endtask

  int          lat, snapR, snapF, snapHi;
  bit          seen;
  logic [3:0]  nextBits;
  int          hold;

  initial begin
    rst = 1'b1; bouncy_in = '0; cnt_sel = 2'd0; cnt_clr = 1'b0;
    @(negedge clk);
    checkOutput("reset_clean_lo", cleanLo, 4'h0);
    checkOutput("reset_clean_hi", cleanHi, 4'hF);
    checkOutput("reset_pulses", {riseLo, fallLo, riseHi, fallHi}, 16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'h0, S + 10);

    // Single clean step on ch0: output follows S+3 edges after the input changes.
    $display("[TB] ch0 step");
    #1 snapR = riseCnt[0][0];
    @(negedge clk);
    bouncy_in[0] = 1'b1;
    lat = 0; seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      lat++;
      if (cleanLo[0]) begin seen = 1'b1; break; end
    end
    checkOutput("ch0_seen", seen, 1'b1);
    checkOutput("ch0_latency", lat, S + 3);
    repeat (3) @(negedge clk);
    #1 checkOutput("ch0_rise_count", riseCnt[0][0] - snapR, 1);
    checkOutput("ch0_others", cleanLo[3:1], 3'b000);

    // ch1 bounces every 2 cycles, then settles high.
    $display("[TB] ch1 bounce");
    @(negedge clk);
    cnt_sel = 2'd1;
    snapR = riseCnt[0][1]; snapF = fallCnt[0][1];
    for (int i = 0; i < 5; i++) applyStimulus({bouncy_in[3:2], 1'(~i[0]), bouncy_in[0]}, 2);
    applyStimulus(bouncy_in, S + 10);
    #1 checkOutput("ch1_rise_count", riseCnt[0][1] - snapR, 1);
    checkOutput("ch1_fall_count", fallCnt[0][1] - snapF, 0);
    checkOutput("ch1_bounce_cnt", cntLo, BOUNCE_EN ? 16'd5 : 16'd0);
    @(negedge clk);

    // Short low glitch on ch2 inside a stable-high period.
    $display("[TB] ch2 glitch");
    applyStimulus(bouncy_in | 4'b0100, S + 10);
    #1 snapF = fallCnt[0][2];
    @(negedge clk);
    applyStimulus(bouncy_in & 4'b1011, 2);
    applyStimulus(bouncy_in | 4'b0100, S + 10);
    #1 checkOutput("ch2_no_fall", fallCnt[0][2] - snapF, 0);
    checkOutput("ch2_level", cleanLo[2], 1'b1);
    @(negedge clk);

    // ch0 and ch3 rise together.
    $display("[TB] ch0+ch3 together");
    applyStimulus(bouncy_in & 4'b0110, S + 10);
    bouncy_in = bouncy_in | 4'b1001;
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (anyLo) begin seen = 1'b1; break; end
    end
    checkOutput("pair_seen", seen, 1'b1);
    checkOutput("pair_rise", riseLo, 4'b1001);
    checkOutput("pair_fall", fallLo, 4'b0000);
    @(negedge clk);
    checkOutput("pair_any_one_cycle", anyLo, 1'b0);

    // Continuous toggling saturates the ch0 bounce counter; clear collides with an increment.
    $display("[TB] saturation");
    cnt_sel = 2'd0;
    for (int i = 0; i < 65600; i++) begin
      bouncy_in[0] = ~bouncy_in[0];
      @(negedge clk);
    end
    checkOutput("ch0_saturated", cntLo, BOUNCE_EN ? 16'hFFFF : 16'h0);
    bouncy_in[0] = ~bouncy_in[0];
    @(negedge clk);
    cnt_clr = 1'b1; bouncy_in[0] = ~bouncy_in[0];
    @(negedge clk);
    cnt_clr = 1'b0; bouncy_in[0] = ~bouncy_in[0];
    @(negedge clk);
    checkOutput("ch0_clear_wins", cntLo, 16'h0);
    applyStimulus(4'h0, S + 10);

    // Reset two cycles before a pending update.
    $display("[TB] reset abort");
    applyStimulus(4'hF, S + 1);
    #1 snapR = 0; snapHi = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      snapR  += riseCnt[0][c] + fallCnt[0][c];
      snapHi += riseCnt[1][c] + fallCnt[1][c];
    end
    rst = 1'b1;
    #1 checkOutput("abort_clean_hi", cleanHi, 4'hF);
    checkOutput("abort_clean_lo", cleanLo, 4'h0);
    checkOutput("abort_pulses", {riseLo, fallLo, riseHi, fallHi}, 16'h0);
    checkOutput("abort_bcnt_hi", cntHi, 16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (S) @(negedge clk);
    #1 lat = 0; hold = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      lat  += riseCnt[0][c] + fallCnt[0][c];
      hold += riseCnt[1][c] + fallCnt[1][c];
    end
    checkOutput("abort_no_pulse_lo", lat - snapR, 0);
    checkOutput("abort_no_pulse_hi", hold - snapHi, 0);
    @(negedge clk);

    // Random bouncing, selects, clears and occasional resets.
    $display("[TB] random");
    for (int it = 0; it < 400; it++) begin
      nextBits = bouncy_in ^ 4'($urandom_range(0, 15));
      hold     = $urandom_range(1, 2 * S + 2);
      cnt_sel  = 2'($urandom_range(0, 3));
      cnt_clr  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      applyStimulus(nextBits, hold);
    end
    cnt_clr = 1'b0;
    applyStimulus(bouncy_in, S + 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
